// File: rtl/adbg_crc32_check_pkg.sv
// Shared definitions for the serial CRC-32 checker.
// Holds the CRC seed, the reflected polynomial, the CRC width and the
// 2-bit FSM state encoding used by adbg_crc32_check.
package adbg_crc32_check_pkg;

    localparam int          CRC_W         = 32;
    localparam logic [31:0] CRC_SEED      = 32'hFFFF_FFFF;
    localparam logic [31:0] ADBG_CRC_POLY = 32'hEDB8_8320;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/adbg_crc32_check_if.sv
// Bus bundle between the JTAG receive path (master) and the CRC checker (slave).
// Signals:
//   start, len, bit_valid, bit_in        master -> checker
//   busy, done, crc_ok, crc_err, crc_value  checker -> master
//   err_cnt                               checker -> master, only when
//                                         ADBG_CRC_CHECK_ERRCNT_EN is defined
interface adbg_crc32_check_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             bit_valid;
    logic             bit_in;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic             crc_err;
    logic [31:0]      crc_value;
`ifdef ADBG_CRC_CHECK_ERRCNT_EN
    logic [7:0]       err_cnt;

    modport master (
        output start, len, bit_valid, bit_in,
        input  busy, done, crc_ok, crc_err, crc_value, err_cnt
    );
    modport slave (
        input  start, len, bit_valid, bit_in,
        output busy, done, crc_ok, crc_err, crc_value, err_cnt
    );
`else
    modport master (
        output start, len, bit_valid, bit_in,
        input  busy, done, crc_ok, crc_err, crc_value
    );
    modport slave (
        input  start, len, bit_valid, bit_in,
        output busy, done, crc_ok, crc_err, crc_value
    );
`endif
endinterface

// File: rtl/adbg_crc32_step.sv
// One-bit reflected CRC-32 update (right-shifting, poly 0xEDB88320).
// Ports:
//   crc_i  in  32  current CRC
//   bit_i  in  1   incoming data bit
//   crc_o  out 32  CRC after absorbing bit_i
module adbg_crc32_step
    import adbg_crc32_check_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic        bit_i,
    output logic [31:0] crc_o
);
    logic        fb;
    logic [31:0] shifted;

    assign fb      = crc_i[0] ^ bit_i;
    assign shifted = {1'b0, crc_i[31:1]};

    // Polynomial taps applied per bit position.
    generate
        for (genvar gi = 0; gi < CRC_W; gi++) begin : g_tap
            assign crc_o[gi] = shifted[gi] ^ (fb & ADBG_CRC_POLY[gi]);
        end
    endgenerate
endmodule

// File: rtl/adbg_crc32_check.sv
// Serial CRC-32 checker on the host->target debug receive path.
// Accumulates CRC over a len-bit data field (LSB first), then compares the
// next 32 received bits against the accumulated CRC and reports the verdict.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   adbg_crc32_check_if.slave (start/len/bit_valid/bit_in in;
//         busy/done/crc_ok/crc_err/crc_value[/err_cnt] out)
// Parameter: LEN_W  width of len and the bit counter (must be >= 6 so the
//            counter can hold the 32 CRC bits).
// Optional feature: define ADBG_CRC_CHECK_ERRCNT_EN to add the saturating
// 8-bit mismatch counter err_cnt.
module adbg_crc32_check
    import adbg_crc32_check_pkg::*;
#(
    parameter int LEN_W = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    adbg_crc32_check_if.slave    bus
);
    localparam logic [LEN_W-1:0] CNT_CHECK = LEN_W'(CRC_W);
    localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic             mism_q, mism_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic [31:0]      crc_step;
    logic             mism_now;
`ifdef ADBG_CRC_CHECK_ERRCNT_EN
    logic [7:0]       err_cnt_q, err_cnt_d;
`endif

    adbg_crc32_step u_step (
        .crc_i (crc_q),
        .bit_i (bus.bit_in),
        .crc_o (crc_step)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        mism_d   = mism_q;
        done_d   = 1'b0;
        ok_d     = ok_q;
        err_d    = err_q;
        mism_now = mism_q | (bus.bit_in ^ crc_q[0]);
`ifdef ADBG_CRC_CHECK_ERRCNT_EN
        err_cnt_d = err_cnt_q;
`endif
        // start has priority over any bit in the same cycle and aborts a
        // frame in progress without producing done.
        if (bus.start) begin
            crc_d  = CRC_SEED;
            mism_d = 1'b0;
            ok_d   = 1'b0;
            err_d  = 1'b0;
            if (bus.len != '0) begin
                state_d = ST_DATA;
                cnt_d   = bus.len;
            end else begin
                state_d = ST_CHECK;
                cnt_d   = CNT_CHECK;
            end
        end else if (bus.bit_valid) begin
            case (state_q)
                ST_DATA: begin
                    crc_d = crc_step;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_CHECK;
                        cnt_d   = CNT_CHECK;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_CHECK: begin
                    // Shift the CRC out LSB first so crc_q[0] is always the
                    // bit expected next.
                    crc_d  = {1'b0, crc_q[31:1]};
                    mism_d = mism_now;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        ok_d    = ~mism_now;
                        err_d   = mism_now;
`ifdef ADBG_CRC_CHECK_ERRCNT_EN
                        if (mism_now && (err_cnt_q != 8'hFF))
                            err_cnt_d = err_cnt_q + 8'd1;
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            crc_q   <= CRC_SEED;
            mism_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            mism_q  <= mism_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

`ifdef ADBG_CRC_CHECK_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= 8'h00;
        else     err_cnt_q <= err_cnt_d;
    end
    assign bus.err_cnt = err_cnt_q;
`endif

    assign bus.busy      = (state_q == ST_DATA) || (state_q == ST_CHECK);
    assign bus.done      = done_q;
    assign bus.crc_ok    = ok_q;
    assign bus.crc_err   = err_q;
    assign bus.crc_value = crc_q;
endmodule

// File: tb/tb_adbg_crc32_check.sv
module tb_adbg_crc32_check;
    localparam int LEN_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adbg_crc32_check_if #(.LEN_W(LEN_W)) bus ();
    adbg_crc32_check #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int exp_err_cnt = 0;

    typedef struct {
        logic ok;
        logic err;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    function automatic logic [31:0] model_step(input logic [31:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
    endfunction

    function automatic logic [31:0] model_crc(input int n, input logic [63:0] data);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) c = model_step(c, data[i]);
        return c;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l, input logic collide, input logic cbit);
        bus.start     = 1'b1;
        bus.len       = LEN_W'(l);
        bus.bit_valid = collide;
        bus.bit_in    = cbit;
        cyc();
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) cyc();
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        cyc();
        bus.bit_valid = 1'b0;
    endtask

    task automatic run_frame(input string name, input int n, input logic [63:0] data,
                             input logic [31:0] crc_tx, input int gap, input logic collide);
        logic [31:0] m;
        exp_t e;
        int d0;
        m     = model_crc(n, data);
        e.ok  = (crc_tx == m);
        e.err = (crc_tx != m);
        sb_q.push_back(e);
        d0 = done_cnt;
        do_start(n, collide, ~data[0]);
        vectors++;
        if (bus.busy !== 1'b1 || bus.crc_ok !== 1'b0 || bus.crc_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s start: busy/ok/err=%b%b%b required 100", name, bus.busy, bus.crc_ok, bus.crc_err);
        end
        for (int i = 0; i < n; i++) send_bit(data[i], gap);
        vectors++;
        if (bus.crc_value !== m) begin
            miscompares++;
            $display("FAIL %s data_crc: got %h required %h", name, bus.crc_value, m);
        end
        for (int i = 0; i < 32; i++) send_bit(crc_tx[i], gap);
        vectors++;
        if (bus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_latency: done=%b required 1", name, bus.done);
        end
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard: queue empty required 1 entry", name);
        end else begin
            e = sb_q.pop_front();
            if (e.err && exp_err_cnt < 255) exp_err_cnt++;
            if (bus.crc_ok !== e.ok || bus.crc_err !== e.err) begin
                miscompares++;
                $display("FAIL %s flags: ok/err=%b%b required %b%b", name, bus.crc_ok, bus.crc_err, e.ok, e.err);
            end
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.crc_value !== 32'h0) begin
            miscompares++;
            $display("FAIL %s end_state: busy=%b crc=%h required 0 00000000", name, bus.busy, bus.crc_value);
        end
`ifdef ADBG_CRC_CHECK_ERRCNT_EN
        vectors++;
        if (bus.err_cnt !== 8'(exp_err_cnt)) begin
            miscompares++;
            $display("FAIL %s err_cnt: got %0d required %0d", name, bus.err_cnt, exp_err_cnt);
        end
`endif
        cyc();
        vectors++;
        if (bus.done !== 1'b0 || (done_cnt - d0) != 1) begin
            miscompares++;
            $display("FAIL %s done_width: done=%b pulses=%0d required 0 1", name, bus.done, done_cnt - d0);
        end
        $display("frame %s len=%0d gap=%0d crc_tx=%h ok=%b err=%b", name, n, gap, crc_tx, bus.crc_ok, bus.crc_err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.crc_ok !== 1'b0 ||
            bus.crc_err !== 1'b0 || bus.crc_value !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL reset: busy/done/ok/err=%b%b%b%b crc=%h required 0000 ffffffff",
                     bus.busy, bus.done, bus.crc_ok, bus.crc_err, bus.crc_value);
        end
`ifdef ADBG_CRC_CHECK_ERRCNT_EN
        vectors++;
        if (bus.err_cnt !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_err_cnt: got %0d required 0", bus.err_cnt);
        end
`endif
        $display("reset checked");
    endtask

    task automatic test_good_frame();
        run_frame("good", 1, 64'h0, 32'h92477CDF, 0, 1'b0);
    endtask

    task automatic test_bad_frame();
        run_frame("bad_bit7", 1, 64'h0, 32'h92477CDF ^ 32'h80, 0, 1'b0);
    endtask

    task automatic test_len_zero();
        run_frame("len_zero", 0, 64'h0, 32'hFFFFFFFF, 0, 1'b0);
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        do_start(8, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(i[0], 0);
        run_frame("abort_restart", 1, 64'h1, 32'h7FFFFFFF, 0, 1'b0);
        repeat (3) cyc();
        vectors++;
        if ((done_cnt - d0) != 1) begin
            miscompares++;
            $display("FAIL abort_done_count: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_rst_check();
        logic [31:0] c;
        int d0;
        c = 32'h92477CDF;
        d0 = done_cnt;
        do_start(1, 1'b0, 1'b0);
        send_bit(1'b0, 0);
        for (int i = 0; i < 10; i++) send_bit(c[i], 0);
        rst = 1'b1;
        #1;
        exp_err_cnt = 0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.crc_value !== 32'hFFFFFFFF ||
            bus.crc_ok !== 1'b0 || bus.crc_err !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_check: busy=%b crc=%h ok/err/done=%b%b%b required 0 ffffffff 000",
                     bus.busy, bus.crc_value, bus.crc_ok, bus.crc_err, bus.done);
        end
`ifdef ADBG_CRC_CHECK_ERRCNT_EN
        vectors++;
        if (bus.err_cnt !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_err_cnt: got %0d required 0", bus.err_cnt);
        end
`endif
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 10; i < 32; i++) send_bit(c[i], 0);
        cyc();
        vectors++;
        if ((done_cnt - d0) != 0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_done: pulses=%0d busy=%b required 0 0", done_cnt - d0, bus.busy);
        end
        $display("rst during CHECK checked");
    endtask

    task automatic test_gaps();
        run_frame("gap3", 1, 64'h0, 32'h92477CDF, 2, 1'b0);
    endtask

    task automatic test_start_wins();
        run_frame("start_and_bit", 1, 64'h0, 32'h92477CDF, 0, 1'b1);
    endtask

    task automatic test_random();
        int n;
        logic [63:0] d;
        logic [31:0] m;
        logic [31:0] flip;
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(40, 1);
            d = {$urandom(), $urandom()};
            m = model_crc(n, d);
            flip = (k % 2 == 1) ? (32'h1 << $urandom_range(31, 0)) : 32'h0;
            run_frame("random", n, d, m ^ flip, k % 3, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_len_zero();
        test_abort();
        test_rst_check();
        test_gaps();
        test_start_wins();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
